// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 result processor: FSM encoding,
// millisecond prescaler derivation and BCD saturation limits.
package dht11_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_DONE,
        CONVERT,
        HOLD
    } state_t;

    localparam logic [7:0] BCD_INT_MAX  = 8'd99;
    localparam logic [7:0] BCD_FRAC_MAX = 8'd9;

    // Clock cycles per 1 ms tick; never below one cycle.
    function automatic int ms_tick_div(input int clk_freq);
        return (clk_freq >= 2000) ? clk_freq / 1000 : 1;
    endfunction

    function automatic logic [7:0] clamp8(input logic [7:0] v, input logic [7:0] max_v);
        return (v > max_v) ? max_v : v;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: 8-bit binary (0..99) to two BCD digits,
// one bit per cycle, busy for exactly 8 cycles, result and done land together.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [7:0] bcd
);
    logic [7:0] shift_reg, work_reg, bcd_reg;
    logic [7:0] adj, step;
    logic       step_unused;
    logic [2:0] cnt_reg;
    logic       busy_reg, done_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_digit
            assign adj[gi*4 +: 4] = (work_reg[gi*4 +: 4] >= 4'd5) ? work_reg[gi*4 +: 4] + 4'd3
                                                                  : work_reg[gi*4 +: 4];
        end
    endgenerate

    // Inputs are clamped to 99 upstream, so the bit shifted out of the tens digit is always 0.
    assign {step_unused, step} = {adj, shift_reg[7]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_reg <= '0;
            work_reg  <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (busy_reg) begin
                work_reg  <= step;
                shift_reg <= {shift_reg[6:0], 1'b0};
                cnt_reg   <= cnt_reg + 3'd1;
                if (cnt_reg == 3'd7) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                    bcd_reg  <= step;
                end
            end else if (start) begin
                shift_reg <= bin;
                work_reg  <= '0;
                cnt_reg   <= '0;
                busy_reg  <= 1'b1;
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule

// File: rtl/dht11_result_proc.sv
// Periodic DHT11 measurement sequencer with saturating capture and BCD conversion.
// Define DHT11_ERRCNT_EN to add the saturating err_cnt failure counter output.
module dht11_result_proc #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int PERIOD_MS  = 2000,
    parameter int TIMEOUT_MS = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] humidity,
    input  logic [15:0] temperature,
    input  logic        dht11_done,
    input  logic        dht11_valid,
    output logic        start,
    output logic [7:0]  hum_bcd,
    output logic [7:0]  temp_bcd,
    output logic [3:0]  temp_frac,
    output logic        data_ready,
`ifdef DHT11_ERRCNT_EN
    output logic [7:0]  err_cnt,
`endif
    output logic        stale
);
    import dht11_pkg::*;

    localparam int DIV    = ms_tick_div(CLK_FREQ);
    localparam int PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MS_MAX = (PERIOD_MS > TIMEOUT_MS) ? PERIOD_MS : TIMEOUT_MS;
    localparam int MW     = $clog2(MS_MAX + 1);

    state_t        state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_eff;
    logic [MW-1:0] ms_cnt_reg, ms_eff;
    logic          tick, timed_out, period_done;
    logic          capture, fail, finish;
    logic [2:0]    conv_cnt_reg;
    logic [3:0]    frac_sat, frac_cap_reg, temp_frac_reg;
    logic          stale_reg;
    logic [1:0]    conv_busy, conv_done;
    logic [7:0]    conv_bin [2];
    logic [7:0]    conv_bcd [2];
    logic          hum_frac_unused;

    assign hum_frac_unused = ^humidity[7:0];

    // TRIG restarts the ms timebase so period and timeout are measured from the start pulse.
    always_comb begin
        presc_eff   = (state_reg == TRIG) ? '0 : presc_reg;
        ms_eff      = (state_reg == TRIG) ? '0 : ms_cnt_reg;
        tick        = (presc_eff == PW'(DIV - 1));
        timed_out   = (tick && ms_eff == MW'(TIMEOUT_MS - 1)) || (ms_eff >= MW'(TIMEOUT_MS));
        period_done = (tick && ms_eff == MW'(PERIOD_MS - 1)) || (ms_eff >= MW'(PERIOD_MS));
        frac_sat    = (temperature[7:0] > BCD_FRAC_MAX) ? 4'(BCD_FRAC_MAX) : temperature[3:0];
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        fail       = 1'b0;
        finish     = 1'b0;
        unique case (state_reg)
            IDLE:      if (enable) state_next = TRIG;
            TRIG:      state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (dht11_done && dht11_valid) begin
                    capture    = 1'b1;
                    state_next = CONVERT;
                end else if (dht11_done || timed_out) begin
                    fail       = 1'b1;
                    state_next = HOLD;
                end
            end
            CONVERT: begin
                if (conv_cnt_reg == 3'd7) begin
                    finish     = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD:      if (period_done) state_next = enable ? TRIG : IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            presc_reg     <= '0;
            ms_cnt_reg    <= '0;
            conv_cnt_reg  <= '0;
            frac_cap_reg  <= '0;
            temp_frac_reg <= '0;
            stale_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                presc_reg  <= '0;
                ms_cnt_reg <= '0;
            end else begin
                presc_reg  <= tick ? '0 : presc_eff + 1'b1;
                ms_cnt_reg <= (tick && ms_eff != MW'(MS_MAX)) ? ms_eff + 1'b1 : ms_eff;
            end
            if (capture) begin
                conv_cnt_reg <= '0;
                frac_cap_reg <= frac_sat;
            end else if (state_reg == CONVERT && |conv_busy) begin
                conv_cnt_reg <= conv_cnt_reg + 3'd1;
            end
            if (fail) begin
                stale_reg <= 1'b1;
            end else if (finish) begin
                stale_reg     <= 1'b0;
                temp_frac_reg <= frac_cap_reg;
            end
        end
    end

    assign conv_bin[0] = clamp8(humidity[15:8], BCD_INT_MAX);
    assign conv_bin[1] = clamp8(temperature[15:8], BCD_INT_MAX);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_conv
            bin2bcd_seq u_bin2bcd (
                .clk   (clk),
                .rst   (rst),
                .start (capture),
                .bin   (conv_bin[gi]),
                .busy  (conv_busy[gi]),
                .done  (conv_done[gi]),
                .bcd   (conv_bcd[gi])
            );
        end
    endgenerate

`ifdef DHT11_ERRCNT_EN
    logic [7:0] err_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            err_cnt_reg <= '0;
        end else if (fail && err_cnt_reg != 8'hFF) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

    assign start      = (state_reg == TRIG);
    assign hum_bcd    = conv_bcd[0];
    assign temp_bcd   = conv_bcd[1];
    assign temp_frac  = temp_frac_reg;
    assign data_ready = &conv_done;
    assign stale      = stale_reg;

endmodule

// File: tb/tb_dht11_result_proc.sv
// Randomized self-checking bench for dht11_result_proc (10 cycles per ms,
// 50-cycle period, 20-cycle timeout) against a decimal reference model.
`timescale 1ns/1ps
module tb_dht11_result_proc;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        dht11_done = 1'b0;
    logic        dht11_valid = 1'b0;
    logic [15:0] humidity = '0;
    logic [15:0] temperature = '0;
    logic        start, data_ready, stale;
    logic [7:0]  hum_bcd, temp_bcd;
    logic [3:0]  temp_frac;
`ifdef DHT11_ERRCNT_EN
    logic [7:0]  err_cnt;
    int          exp_err = 0;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t_start = 0;
    logic [7:0]  exp_hum = '0;
    logic [7:0]  exp_temp = '0;
    logic [3:0]  exp_frac = '0;
    logic        exp_stale = 1'b0;

    localparam int PERIOD_CYC = 50;

    dht11_result_proc #(
        .CLK_FREQ   (10_000),
        .PERIOD_MS  (5),
        .TIMEOUT_MS (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .humidity    (humidity),
        .temperature (temperature),
        .dht11_done  (dht11_done),
        .dht11_valid (dht11_valid),
        .start       (start),
        .hum_bcd     (hum_bcd),
        .temp_bcd    (temp_bcd),
        .temp_frac   (temp_frac),
        .data_ready  (data_ready),
`ifdef DHT11_ERRCNT_EN
        .err_cnt     (err_cnt),
`endif
        .stale       (stale)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reference: saturate to 99 then split into decimal tens/units.
    function automatic logic [7:0] ref_bcd(input int v);
        int c;
        c = (v > 99) ? 99 : v;
        return 8'((c / 10) * 16 + (c % 10));
    endfunction

    function automatic logic [3:0] ref_frac(input int v);
        return 4'((v > 9) ? 9 : v);
    endfunction

    task automatic note_failure();
        exp_stale = 1'b1;
`ifdef DHT11_ERRCNT_EN
        if (exp_err < 255) exp_err++;
`endif
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_hum_bcd"}, hum_bcd, exp_hum);
        check_eq({tag, "_temp_bcd"}, temp_bcd, exp_temp);
        check_eq({tag, "_temp_frac"}, temp_frac, exp_frac);
        check_eq({tag, "_stale"}, stale, exp_stale);
`ifdef DHT11_ERRCNT_EN
        check_eq({tag, "_err_cnt"}, err_cnt, exp_err);
`endif
    endtask

    task automatic wait_start();
        int   n;
        int   want;
        logic dr;
        n    = 0;
        dr   = 1'b0;
        want = t_start + PERIOD_CYC - cyc;
        while (start !== 1'b1 && n < 200) begin
            tick();
            n++;
            dr |= data_ready;
        end
        $display("txn start at cycle %0d (gap %0d)", cyc, cyc - t_start);
        check_eq("start_period", n, want);
        check_eq("no_stray_ready", dr, 1'b0);
        t_start = cyc;
        check_outputs("at_start");
        tick();
        check_eq("start_width", start, 1'b0);
    endtask

    task automatic do_valid(input logic [15:0] h, input logic [15:0] t, input int d);
        logic dr;
        dr = 1'b0;
        tick_n(t_start + d - cyc);
        humidity    = h;
        temperature = t;
        dht11_done  = 1'b1;
        dht11_valid = 1'b1;
        tick();
        dht11_done  = 1'b0;
        dht11_valid = 1'($urandom);
        humidity    = 16'($urandom);
        temperature = 16'($urandom);
        for (int i = 0; i < 8; i++) begin
            dr |= data_ready;
            tick();
        end
        exp_hum   = ref_bcd(int'(h[15:8]));
        exp_temp  = ref_bcd(int'(t[15:8]));
        exp_frac  = ref_frac(int'(t[7:0]));
        exp_stale = 1'b0;
        $display("txn valid h=%04h t=%04h delay=%0d -> %02h %02h %0h", h, t, d, exp_hum, exp_temp, exp_frac);
        check_eq("ready_early", dr, 1'b0);
        check_eq("ready_pulse", data_ready, 1'b1);
        check_outputs("conv");
        tick();
        check_eq("ready_width", data_ready, 1'b0);
    endtask

    task automatic do_invalid(input int d);
        tick_n(t_start + d - cyc);
        humidity    = 16'($urandom);
        temperature = 16'($urandom);
        dht11_done  = 1'b1;
        dht11_valid = 1'b0;
        tick();
        dht11_done = 1'b0;
        note_failure();
        $display("txn bad checksum delay=%0d", d);
        check_outputs("bad_crc");
        check_eq("bad_crc_ready", data_ready, 1'b0);
    endtask

    task automatic do_timeout();
        tick_n(t_start + 19 - cyc);
        check_eq("pre_timeout_stale", stale, exp_stale);
        tick();
        note_failure();
        $display("txn timeout");
        check_outputs("timeout");
        tick_n(t_start + 25 - cyc);
        humidity    = 16'h3300;
        temperature = 16'h1102;
        dht11_done  = 1'b1;
        dht11_valid = 1'b1;
        tick();
        dht11_done = 1'b0;
        check_outputs("late_done");
    endtask

    initial begin
        logic st;
        logic dr;

        tick_n(3);
        check_outputs("reset");
        check_eq("reset_start", start, 1'b0);
        check_eq("reset_ready", data_ready, 1'b0);
        rst = 1'b1;
        tick_n(3);
        check_eq("idle_no_start", start, 1'b0);

        enable = 1'b1;
        tick();
        check_eq("first_start", start, 1'b1);
        t_start = cyc;
        tick();
        check_eq("start_width", start, 1'b0);

        do_valid(16'h2D00, 16'h1805, 3);
        wait_start();
        do_valid(16'hC800, 16'h0063, 7);
        wait_start();
        do_invalid(2);
        wait_start();
        do_timeout();
        wait_start();

        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 3))
                0, 1:    do_valid(16'($urandom), 16'($urandom), int'($urandom_range(1, 18)));
                2:       do_invalid(int'($urandom_range(1, 18)));
                default: do_timeout();
            endcase
            wait_start();
        end

        // Drop enable while waiting: the transaction still completes, then no more starts.
        tick();
        enable = 1'b0;
        do_valid(16'h3700, 16'h1509, 6);
        st = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            st |= start;
        end
        check_eq("no_start_after_disable", st, 1'b0);

        // Reset in the middle of a conversion abandons it.
        enable = 1'b1;
        tick();
        check_eq("restart", start, 1'b1);
        t_start = cyc;
        tick_n(2);
        humidity    = 16'h4200;
        temperature = 16'h2000;
        dht11_done  = 1'b1;
        dht11_valid = 1'b1;
        tick();
        dht11_done = 1'b0;
        tick_n(3);
        rst    = 1'b0;
        enable = 1'b0;
        tick();
        rst       = 1'b1;
        exp_hum   = '0;
        exp_temp  = '0;
        exp_frac  = '0;
        exp_stale = 1'b0;
`ifdef DHT11_ERRCNT_EN
        exp_err = 0;
`endif
        $display("txn reset during convert");
        check_outputs("mid_conv_reset");
        check_eq("mid_conv_reset_start", start, 1'b0);
        check_eq("mid_conv_reset_ready", data_ready, 1'b0);
        dr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            dr |= data_ready;
        end
        check_eq("no_ready_after_reset", dr, 1'b0);
        check_outputs("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dht11_result_proc.md
DHT11_RESULT_PROC -- requirements
Module: dht11_result_proc

Interface
REQ-001 Param CLK_FREQ, default 100_000_000, system clock in Hz.
REQ-002 Param PERIOD_MS, default 2000, measurement repeat period in ms.
REQ-003 Param TIMEOUT_MS, default 50, max wait from start to dht11_done in ms.
REQ-004 clk  in  1  single system clock, all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 enable  in  1  1 = periodic measurement active.
REQ-007 humidity  in  16  sensor humidity, [15:8] integer, [7:0] decimal.
REQ-008 temperature  in  16  sensor temperature, [15:8] integer, [7:0] decimal.
REQ-009 dht11_done  in  1  one-cycle pulse, sensor transaction finished.
REQ-010 dht11_valid  in  1  checksum OK, qualified by dht11_done.
REQ-011 start  out  1  one-cycle pulse requesting a sensor read.
REQ-012 hum_bcd  out  8  humidity integer, two BCD digits.
REQ-013 temp_bcd  out  8  temperature integer, two BCD digits.
REQ-014 temp_frac  out  4  temperature decimal digit, BCD.
REQ-015 data_ready  out  1  one-cycle pulse, new BCD outputs valid.
REQ-016 stale  out  1  last attempt failed (timeout or bad checksum).

Function
REQ-017 Internal 1 ms tick from a CLK_FREQ/1000 counter; all period and timeout counting on this tick only.
REQ-018 FSM states IDLE, TRIG, WAIT_DONE, CONVERT, HOLD.
REQ-019 IDLE: enable=1 -> TRIG next cycle; enable=0 -> remain, period counter held at 0.
REQ-020 TRIG: start=1 for exactly this cycle, timeout counter cleared, -> WAIT_DONE.
REQ-021 WAIT_DONE: dht11_done&dht11_valid -> capture humidity[15:8], temperature[15:8], temperature[7:0] -> CONVERT.
REQ-022 WAIT_DONE: dht11_done&!dht11_valid -> stale=1, BCD outputs unchanged -> HOLD.
REQ-023 WAIT_DONE: TIMEOUT_MS ticks without dht11_done -> stale=1 -> HOLD; a later dht11_done is ignored.
REQ-024 Capture saturates: integer >99 clamps to 99; decimal >9 clamps to 9.
REQ-025 CONVERT: sequential shift-add-3 (double dabble), one bit per cycle, both integer bytes in parallel, exactly 8 cycles.
REQ-026 Capture at cycle N -> hum_bcd/temp_bcd/temp_frac updated and data_ready=1 at cycle N+9; stale cleared same cycle; -> HOLD.
REQ-027 HOLD: count ms ticks from TRIG entry; at PERIOD_MS -> TRIG if enable=1, else IDLE.
REQ-028 enable falling in WAIT_DONE or CONVERT: current transaction completes, then IDLE.
REQ-029 dht11_done outside WAIT_DONE: ignored, no state or output change.
REQ-030 start never re-asserted before PERIOD_MS elapsed since previous start.

Reset
REQ-031 rst=0 at a rising edge: state IDLE, all counters 0, start=0, data_ready=0, stale=0, hum_bcd=temp_bcd=8'h00, temp_frac=4'h0.
REQ-032 Reset mid-CONVERT or mid-WAIT_DONE abandons the transaction; no data_ready pulse follows.

Configuration
REQ-033 Macro DHT11_ERRCNT_EN defined: extra output err_cnt out 8, increments on each REQ-022/REQ-023 event, saturates at 255, reset to 0.
REQ-034 DHT11_ERRCNT_EN undefined: no err_cnt port, no counter logic; all other behaviour identical.

Structure
REQ-035 Shared package dht11_pkg holds FSM state encoding, MS_TICK_DIV derivation, BCD max constants (99, 9).
REQ-036 One sub-module bin2bcd_seq: 8-bit start/busy/done sequential double-dabble converter, instantiated twice.

Verification
REQ-037 CLK_FREQ=10_000, PERIOD_MS=5, TIMEOUT_MS=2: enable=1 -> start pulse 1 cycle after enable, next start exactly 50 cycles later.
REQ-038 Done+valid with humidity=16'h2D00, temperature=16'h1805 -> 9 cycles later data_ready=1, hum_bcd=8'h45, temp_bcd=8'h24, temp_frac=4'h5, stale=0.
REQ-039 Done with valid=0 -> stale=1, BCD outputs unchanged, no data_ready; err_cnt=1 when DHT11_ERRCNT_EN.
REQ-040 No done for 20 cycles after start -> stale=1; done arriving afterwards -> no output change.
REQ-041 humidity=16'hC8_00 (200) -> hum_bcd=8'h99 after conversion.
REQ-042 rst=0 during CONVERT -> all outputs reset values next edge, no data_ready after rst=1.
